// File: rtl/udar_pkg.sv
// Shared types and constants for the host command/ranging controller.
package udar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_X,
        ST_GET_Y,
        ST_SETTLE,
        ST_MEASURE,
        ST_SEND
    } state_t;

    localparam logic [7:0]  CMD_HDR   = 8'hF0;
    localparam logic [7:0]  RSP_HDR   = 8'h0F;
    localparam logic [7:0]  SERVO_RST = 8'd150;
    localparam int unsigned LEN_W     = 24;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/udar_cycle_timer.sv
// Saturating up-counter shared by the byte-timeout, settle and measure phases;
// expired is high while the count equals the current limit.
module udar_cycle_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic [W-1:0] limit_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != limit_i)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == limit_i);

endmodule

// File: rtl/udar_cmd_ctrl.sv
// Host command decoder: takes {F0, X, Y}, updates the servos, waits to settle,
// runs one ranging measurement and returns {0F, len[23:16], len[15:8], len[7:0]}.
//   state      | meaning
//   ST_IDLE    | waiting for the command header
//   ST_GET_X   | waiting for the pan byte (byte timeout armed)
//   ST_GET_Y   | waiting for the tilt byte (byte timeout armed)
//   ST_SETTLE  | servos moving, counting the settle delay
//   ST_MEASURE | ranging in progress (measure timeout armed)
//   ST_SEND    | streaming the 4-byte response
module udar_cmd_ctrl
    import udar_pkg::*;
#(
    parameter int unsigned BYTE_TIMEOUT  = 50000,
    parameter int unsigned SETTLE_CYCLES = 500,
    parameter int unsigned MEAS_TIMEOUT  = 2000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_new_data,
    output logic [7:0]       tx_data,
    output logic             tx_new_data,
    input  logic             tx_busy,
    output logic [7:0]       servo_x,
    output logic [7:0]       servo_y,
    output logic             pos_valid,
    output logic             meas_start,
    input  logic             meas_done,
    input  logic [LEN_W-1:0] meas_len,
    output logic             busy
);

    localparam int unsigned TMR_MAX = max3(BYTE_TIMEOUT, SETTLE_CYCLES, MEAS_TIMEOUT);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] BYTE_LIM   = TMR_W'(BYTE_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] SETTLE_LIM = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] MEAS_LIM   = TMR_W'(MEAS_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       x_tmp_q, x_tmp_d;
    logic [7:0]       servo_x_q, servo_x_d;
    logic [7:0]       servo_y_q, servo_y_d;
    logic             pos_valid_q, pos_valid_d;
    logic             meas_start_q, meas_start_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_new_q, tx_new_d;
    logic             guard_q, guard_d;

    logic             tmr_clr;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_limit;
    logic             tmr_expired;
    logic [7:0]       rsp_byte;

    udar_cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .clear_i   (tmr_clr),
        .enable_i  (tmr_en),
        .limit_i   (tmr_limit),
        .expired_o (tmr_expired)
    );

    always_comb begin
        rsp_byte = RSP_HDR;
        case (idx_q)
            2'd0:    rsp_byte = RSP_HDR;
            2'd1:    rsp_byte = len_q[23:16];
            2'd2:    rsp_byte = len_q[15:8];
            default: rsp_byte = len_q[7:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        x_tmp_d      = x_tmp_q;
        servo_x_d    = servo_x_q;
        servo_y_d    = servo_y_q;
        len_d        = len_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data_q;
        pos_valid_d  = 1'b0;
        meas_start_d = 1'b0;
        tx_new_d     = 1'b0;
        guard_d      = tx_new_q;
        tmr_en       = 1'b0;
        tmr_limit    = BYTE_LIM;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_new_data && (rx_data == CMD_HDR)) begin
                    state_d = ST_GET_X;
                end
            end
            ST_GET_X: begin
                tmr_en = 1'b1;
                if (rx_new_data) begin
                    x_tmp_d = rx_data;
                    state_d = ST_GET_Y;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GET_Y: begin
                tmr_en = 1'b1;
                if (rx_new_data) begin
                    servo_x_d   = x_tmp_q;
                    servo_y_d   = rx_data;
                    pos_valid_d = 1'b1;
                    state_d     = ST_SETTLE;
                end else if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                tmr_en    = 1'b1;
                tmr_limit = SETTLE_LIM;
                if (tmr_expired) begin
                    meas_start_d = 1'b1;
                    state_d      = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                tmr_en    = 1'b1;
                tmr_limit = MEAS_LIM;
                if (meas_done || tmr_expired) begin
                    len_d   = meas_done ? meas_len : '1;
                    state_d = ST_SEND;
                    idx_d   = 2'd0;
                    // Header does not depend on the length, so it can go out right away.
                    if (!tx_busy) begin
                        tx_data_d = RSP_HDR;
                        tx_new_d  = 1'b1;
                        idx_d     = 2'd1;
                    end
                end
            end
            ST_SEND: begin
                if (!tx_busy && !tx_new_q && !guard_q) begin
                    tx_data_d = rsp_byte;
                    tx_new_d  = 1'b1;
                    idx_d     = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tmr_clr = (state_d != state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            x_tmp_q      <= '0;
            servo_x_q    <= SERVO_RST;
            servo_y_q    <= SERVO_RST;
            pos_valid_q  <= 1'b0;
            meas_start_q <= 1'b0;
            len_q        <= '0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_new_q     <= 1'b0;
            guard_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_tmp_q      <= x_tmp_d;
            servo_x_q    <= servo_x_d;
            servo_y_q    <= servo_y_d;
            pos_valid_q  <= pos_valid_d;
            meas_start_q <= meas_start_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_new_q     <= tx_new_d;
            guard_q      <= guard_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_new_data = tx_new_q;
    assign servo_x     = servo_x_q;
    assign servo_y     = servo_y_q;
    assign pos_valid   = pos_valid_q;
    assign meas_start  = meas_start_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udar_cmd_ctrl.sv
// Self-checking bench for udar_cmd_ctrl: command table plus timeout, drop and reset sequences.
module tb_udar_cmd_ctrl;
    import udar_pkg::*;

    localparam int BYTE_TO     = 2000;
    localparam int SETTLE      = 500;
    localparam int MEAS_TO     = 6000;
    localparam int BYTE_GAP    = 500;
    localparam int TX_BUSY_CYC = 500;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [23:0] len;
        bit          to;
        int          dly;
        bit          junk;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_new_data;
    logic [7:0]  tx_data;
    logic        tx_new_data;
    logic        tx_busy;
    logic [7:0]  servo_x;
    logic [7:0]  servo_y;
    logic        pos_valid;
    logic        meas_start;
    logic        meas_done;
    logic [23:0] meas_len;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    int          pv_cnt   = 0;
    int          tx_cnt   = 0;
    logic [7:0]  exp_q[$];
    vec_t        vt[6];

    always #10 clk = ~clk;

    udar_cmd_ctrl #(
        .BYTE_TIMEOUT  (BYTE_TO),
        .SETTLE_CYCLES (SETTLE),
        .MEAS_TIMEOUT  (MEAS_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_new_data (rx_new_data),
        .tx_data     (tx_data),
        .tx_new_data (tx_new_data),
        .tx_busy     (tx_busy),
        .servo_x     (servo_x),
        .servo_y     (servo_y),
        .pos_valid   (pos_valid),
        .meas_start  (meas_start),
        .meas_done   (meas_done),
        .meas_len    (meas_len),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy registers one cycle after the request and holds for a byte time.
    initial begin
        int  cnt;
        bit  pend;
        cnt     = 0;
        pend    = 1'b0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) tx_busy = 1'b0;
            end
            if (pend) begin
                tx_busy = 1'b1;
                cnt     = TX_BUSY_CYC;
                pend    = 1'b0;
            end
            if (tx_new_data === 1'b1) pend = 1'b1;
        end
    end

    // Scoreboard consumer and pulse counters.
    initial begin
        forever begin
            @(negedge clk);
            if (pos_valid === 1'b1) pv_cnt++;
            if (tx_new_data === 1'b1) begin
                tx_cnt++;
                chk("tx_issued_while_busy", {31'd0, tx_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got byte %0h expected no byte", tx_data);
                end else begin
                    chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data     = b;
        rx_new_data = 1'b1;
        step();
        rx_new_data = 1'b0;
        for (int i = 0; i < gap; i++) step();
    endtask

    task automatic start_cmd(input logic [7:0] x, input logic [7:0] y);
        int k;
        send_byte(CMD_HDR, BYTE_GAP);
        send_byte(x, BYTE_GAP);
        send_byte(y, 0);
        chk("pos_valid_strobe", {31'd0, pos_valid}, 32'd1);
        chk("servo_x", {24'd0, servo_x}, {24'd0, x});
        chk("servo_y", {24'd0, servo_y}, {24'd0, y});
        k = 0;
        while (meas_start !== 1'b1 && k < 2000) begin
            step();
            k++;
        end
        chk("settle_cycles", k, SETTLE);
    endtask

    task automatic run_cmd(input vec_t v);
        int k;
        int pv0;
        int tx0;
        pv0 = pv_cnt;
        tx0 = tx_cnt;
        start_cmd(v.x, v.y);
        exp_q.push_back(v.b0);
        exp_q.push_back(v.b1);
        exp_q.push_back(v.b2);
        exp_q.push_back(v.b3);
        if (v.junk) begin
            send_byte(CMD_HDR, 5);
            send_byte(8'h00, 5);
            send_byte(CMD_HDR, 5);
        end
        if (!v.to) begin
            for (int i = 0; i < v.dly; i++) step();
            meas_done = 1'b1;
            meas_len  = v.len;
            step();
            meas_done = 1'b0;
            k = 1;
            while (tx_new_data !== 1'b1 && k < 20) begin
                step();
                k++;
            end
            chk("rsp_latency_ok", {31'd0, (k >= 1 && k <= 2)}, 32'd1);
        end else begin
            k = 0;
            while (tx_new_data !== 1'b1 && k < 8000) begin
                step();
                k++;
            end
            chk("meas_timeout_cycles", k, MEAS_TO);
        end
        k = 0;
        while (busy === 1'b1 && k < 5000) begin
            step();
            k++;
        end
        chk("busy_drops", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 600; i++) step();
        chk("tx_pulse_count", tx_cnt - tx0, 4);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("pos_valid_count", pv_cnt - pv0, 1);
        chk("servo_x_hold", {24'd0, servo_x}, {24'd0, v.x});
        chk("servo_y_hold", {24'd0, servo_y}, {24'd0, v.y});
    endtask

    task automatic timeout_seq();
        int k;
        int pv0;
        pv0 = pv_cnt;
        send_byte(8'h12, BYTE_GAP);
        send_byte(8'h96, BYTE_GAP);
        chk("idle_ignores_junk", {31'd0, busy}, 32'd0);
        send_byte(CMD_HDR, BYTE_GAP);
        chk("hdr_accepted", {31'd0, busy}, 32'd1);
        send_byte(8'h20, 0);
        k = 0;
        while (busy === 1'b1 && k < 3000) begin
            step();
            k++;
        end
        chk("byte_timeout_cycles", k, BYTE_TO);
        for (int i = 0; i < 10; i++) step();
        chk("timeout_no_pos_valid", pv_cnt - pv0, 0);
        chk("timeout_servo_x", {24'd0, servo_x}, 32'h96);
        chk("timeout_servo_y", {24'd0, servo_y}, 32'h96);
    endtask

    task automatic reset_seq();
        int k;
        int pv0;
        int tx0;
        pv0 = pv_cnt;
        tx0 = tx_cnt;
        start_cmd(8'h55, 8'h66);
        exp_q.push_back(8'h0F);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hEF);
        for (int i = 0; i < 20; i++) step();
        meas_done = 1'b1;
        meas_len  = 24'hABCDEF;
        step();
        meas_done = 1'b0;
        k = 0;
        while (tx_cnt < tx0 + 2 && k < 5000) begin
            step();
            k++;
        end
        chk("bytes_before_rst", tx_cnt - tx0, 2);
        for (int i = 0; i < 100; i++) step();
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_tx_new", {31'd0, tx_new_data}, 32'd0);
        chk("rst_servo_x", {24'd0, servo_x}, {24'd0, SERVO_RST});
        chk("rst_servo_y", {24'd0, servo_y}, {24'd0, SERVO_RST});
        chk("rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) step();
        chk("no_tx_after_rst", tx_cnt - tx0, 2);
        chk("idle_after_rst", {31'd0, busy}, 32'd0);
        chk("servo_x_after_rst", {24'd0, servo_x}, {24'd0, SERVO_RST});
        chk("pos_valid_after_rst", pv_cnt - pv0, 1);
    endtask

    initial begin
        rst         = 1'b1;
        rx_data     = 8'h00;
        rx_new_data = 1'b0;
        meas_done   = 1'b0;
        meas_len    = 24'h0;

        //        x      y      len         to    dly   junk  b0     b1     b2     b3
        vt[0] = '{8'h96, 8'h96, 24'h046D50, 1'b0, 37,   1'b0, 8'h0F, 8'h04, 8'h6D, 8'h50};
        vt[1] = '{8'h10, 8'h20, 24'h000001, 1'b0, 3,    1'b0, 8'h0F, 8'h00, 8'h00, 8'h01};
        vt[2] = '{8'h33, 8'h44, 24'h000000, 1'b1, 0,    1'b0, 8'h0F, 8'hFF, 8'hFF, 8'hFF};
        vt[3] = '{8'hF0, 8'h0F, 24'h123456, 1'b0, 40,   1'b1, 8'h0F, 8'h12, 8'h34, 8'h56};
        vt[4] = '{8'hFF, 8'h00, 24'hFFFFFE, 1'b0, 0,    1'b0, 8'h0F, 8'hFF, 8'hFF, 8'hFE};
        vt[5] = '{8'h01, 8'h02, 24'h00ABCD, 1'b0, 5999, 1'b0, 8'h0F, 8'h00, 8'hAB, 8'hCD};

        for (int i = 0; i < 3; i++) step();
        chk("reset_servo_x", {24'd0, servo_x}, 32'd150);
        chk("reset_servo_y", {24'd0, servo_y}, 32'd150);
        chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
        chk("reset_tx_new", {31'd0, tx_new_data}, 32'd0);
        chk("reset_pos_valid", {31'd0, pos_valid}, 32'd0);
        chk("reset_meas_start", {31'd0, meas_start}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();

        run_cmd(vt[0]);
        timeout_seq();
        for (int i = 1; i < 6; i++) run_cmd(vt[i]);
        reset_seq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
